// File: rtl/udma_hyper_cfg_seq_pkg.sv
// ---------------------------------------------------------------------------
// hyper_cfg_seq_pkg
// Shared types and constants for the HyperBus configuration sequencer.
//   seq_state_e   : sequencer FSM states
//   err_code_e    : error code reported on err_code_o
//   CFG_ADDR_W    : width of the HyperBus config register address
//   CFG_DATA_W    : width of the config data bus
//   TMO_CNT_W     : width of the handshake timeout counter
//   masked_eq     : compare two words under a bit mask
// ---------------------------------------------------------------------------
package hyper_cfg_seq_pkg;

  localparam int unsigned CFG_ADDR_W = 5;
  localparam int unsigned CFG_DATA_W = 32;
  localparam int unsigned TMO_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISMATCH = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ABORT    = 2'b11
  } err_code_e;

  // True when a and b agree on every bit selected by mask.
  function automatic logic masked_eq(input logic [CFG_DATA_W-1:0] a,
                                     input logic [CFG_DATA_W-1:0] b,
                                     input logic [CFG_DATA_W-1:0] mask);
    return ((a ^ b) & mask) == '0;
  endfunction

endpackage

// File: rtl/udma_hyper_cfg_seq_tmo.sv
// ---------------------------------------------------------------------------
// udma_hyper_cfg_seq_tmo
// Handshake timeout counter for the config sequencer. Counts stalled request
// cycles and flags the stall cycle that would bring the count to TIMEOUT.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_clr         : clear the count (handshake or sequencer state change)
//   i_en          : request is valid and not acknowledged this cycle
//   o_expired     : this stalled cycle is the TIMEOUT-th one in a row
// ---------------------------------------------------------------------------
module udma_hyper_cfg_seq_tmo
  import hyper_cfg_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  logic [TMO_CNT_W-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry deliberately ignores i_clr: the clear is derived from the
  // sequencer's next state, which itself depends on this flag. Expiry only
  // fires on a stalled cycle, so it never coincides with a handshake, and
  // the resulting state change clears the count on the same edge.
  assign o_expired = i_en && (r_count == TMO_LAST);

endmodule

// File: rtl/udma_hyper_cfg_seq.sv
// ---------------------------------------------------------------------------
// udma_hyper_cfg_seq
// Configuration-bus initiator that walks an external boot table and programs
// the HyperBus channel register file, optionally reading back each entry to
// verify it. A run stops on the last entry, on a readback mismatch, on a
// handshake timeout or on abort.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i, abort_i     : run control
//   tbl_idx_o            : index of the table entry being processed
//   tbl_addr_i/data_i/mask_i/last_i : combinational table lookup at tbl_idx_o
//   cfg_data_o/addr_o/valid_o/reg_rwn_o : config bus request
//   cfg_data_i, cfg_ready_i             : config bus response
//   busy_o, done_o       : run in progress, one-cycle end-of-run pulse
//   err_o, err_code_o, err_idx_o, err_rdata_o : sticky error report
// ---------------------------------------------------------------------------
module udma_hyper_cfg_seq
  import hyper_cfg_seq_pkg::*;
#(
  parameter int unsigned NB_ENTRIES = 16,
  parameter int unsigned IDX_WIDTH  = (NB_ENTRIES > 1) ? $clog2(NB_ENTRIES) : 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [IDX_WIDTH-1:0]  tbl_idx_o,
  input  logic [CFG_ADDR_W-1:0] tbl_addr_i,
  input  logic [CFG_DATA_W-1:0] tbl_data_i,
  input  logic [CFG_DATA_W-1:0] tbl_mask_i,
  input  logic                  tbl_last_i,
  output logic [CFG_DATA_W-1:0] cfg_data_o,
  output logic [CFG_ADDR_W-1:0] cfg_addr_o,
  output logic                  cfg_valid_o,
  output logic                  cfg_reg_rwn_o,
  input  logic [CFG_DATA_W-1:0] cfg_data_i,
  input  logic                  cfg_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [IDX_WIDTH-1:0]  err_idx_o,
  output logic [CFG_DATA_W-1:0] err_rdata_o
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NB_ENTRIES - 1);

  seq_state_e            r_state;
  seq_state_e            w_state_next;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [IDX_WIDTH-1:0]  w_idx_next;
  logic                  r_err;
  logic                  w_err_next;
  err_code_e             r_err_code;
  err_code_e             w_err_code_next;
  logic [IDX_WIDTH-1:0]  r_err_idx;
  logic [IDX_WIDTH-1:0]  w_err_idx_next;
  logic [CFG_DATA_W-1:0] r_err_rdata;
  logic [CFG_DATA_W-1:0] w_err_rdata_next;

  logic w_active;
  logic w_hs;
  logic w_match;
  logic w_at_end;
  logic w_tmo_en;
  logic w_tmo_clr;
  logic w_tmo_expired;

  assign w_active = (r_state == WR) || (r_state == RD);
  assign w_hs     = w_active && cfg_ready_i;
  assign w_match  = masked_eq(cfg_data_i, tbl_data_i, tbl_mask_i);
  // The walk ends on a flagged last entry or when the table is exhausted.
  assign w_at_end = tbl_last_i || (r_idx == LAST_IDX);

  assign w_tmo_en  = w_active && !cfg_ready_i;
  assign w_tmo_clr = w_hs || (w_state_next != r_state);

  udma_hyper_cfg_seq_tmo #(
    .TIMEOUT (TIMEOUT)
  ) i_tmo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_idx   <= '0;
      r_err_rdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_err       <= w_err_next;
      r_err_code  <= w_err_code_next;
      r_err_idx   <= w_err_idx_next;
      r_err_rdata <= w_err_rdata_next;
    end
  end

  // Abort outranks a same-cycle handshake: the responder may have taken the
  // transfer, but the entry is not counted and the index does not move.
  // A handshake outranks expiry implicitly, since expiry needs ready low.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_err_next       = r_err;
    w_err_code_next  = r_err_code;
    w_err_idx_next   = r_err_idx;
    w_err_rdata_next = r_err_rdata;

    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_idx_next       = '0;
          w_err_next       = 1'b0;
          w_err_code_next  = ERR_NONE;
          w_err_idx_next   = '0;
          w_err_rdata_next = '0;
          w_state_next     = WR;
        end
      end

      WR, RD: begin
        if (abort_i) begin
          w_err_next      = 1'b1;
          w_err_code_next = ERR_ABORT;
          w_err_idx_next  = r_idx;
          w_state_next    = IDLE;
        end else if (w_hs) begin
          if ((r_state == WR) && (tbl_mask_i != '0)) begin
            w_state_next = RD;
          end else if ((r_state == RD) && !w_match) begin
            w_err_next       = 1'b1;
            w_err_code_next  = ERR_MISMATCH;
            w_err_idx_next   = r_idx;
            w_err_rdata_next = cfg_data_i;
            w_state_next     = ERR;
          end else if (w_at_end) begin
            w_state_next = DONE;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = WR;
          end
        end else if (w_tmo_expired) begin
          w_err_next      = 1'b1;
          w_err_code_next = ERR_TIMEOUT;
          w_err_idx_next  = r_idx;
          w_state_next    = ERR;
        end
      end

      DONE, ERR: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Address and data follow the registered table index, so they are stable
  // for the whole request; they are forced to zero while no request is up.
  assign cfg_valid_o   = w_active;
  assign cfg_reg_rwn_o = (r_state == RD);
  assign cfg_addr_o    = w_active ? tbl_addr_i : '0;
  assign cfg_data_o    = w_active ? tbl_data_i : '0;

  assign tbl_idx_o   = r_idx;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE) || (r_state == ERR);
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;
  assign err_idx_o   = r_err_idx;
  assign err_rdata_o = r_err_rdata;

endmodule

// File: tb/tb_udma_hyper_cfg_seq.sv
`timescale 1ns/1ps
// Directed bench for udma_hyper_cfg_seq. A scoreboard queue holds the
// config-bus transfers each run should produce; every handshake pops and
// compares one entry.
module tb_udma_hyper_cfg_seq;

   localparam int NB  = 16;
   localparam int IW  = 4;
   localparam int TMO = 4;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        rwn;
   } txn_t;

   logic          clock = 1'b0;
   logic          rstN;
   logic          start;
   logic          abort;
   logic [IW-1:0] tblIdx;
   logic [4:0]    tblAddr;
   logic [31:0]   tblData;
   logic [31:0]   tblMask;
   logic          tblLast;
   logic [31:0]   cfgData;
   logic [4:0]    cfgAddr;
   logic          cfgValid;
   logic          cfgRwn;
   logic [31:0]   cfgRdata;
   logic          cfgReady;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    errCode;
   logic [IW-1:0] errIdx;
   logic [31:0]   errRdata;

   logic [4:0]  tAddr [NB];
   logic [31:0] tData [NB];
   logic [31:0] tMask [NB];
   logic        tLast [NB];

   txn_t expQ [$];
   int   checks = 0;
   int   failures = 0;
   int   cycleNo = 0;
   int   validCycles = 0;
   int   runStart;

   // Clock generation
   always #5 clock = ~clock;

   // Table lookup driven by the DUT's registered index
   assign tblAddr = tAddr[tblIdx];
   assign tblData = tData[tblIdx];
   assign tblMask = tMask[tblIdx];
   assign tblLast = tLast[tblIdx];

   udma_hyper_cfg_seq #(
      .NB_ENTRIES (NB),
      .IDX_WIDTH  (IW),
      .TIMEOUT    (TMO)
   ) dut (
      .clk_i         (clock),
      .rst_ni        (rstN),
      .start_i       (start),
      .abort_i       (abort),
      .tbl_idx_o     (tblIdx),
      .tbl_addr_i    (tblAddr),
      .tbl_data_i    (tblData),
      .tbl_mask_i    (tblMask),
      .tbl_last_i    (tblLast),
      .cfg_data_o    (cfgData),
      .cfg_addr_o    (cfgAddr),
      .cfg_valid_o   (cfgValid),
      .cfg_reg_rwn_o (cfgRwn),
      .cfg_data_i    (cfgRdata),
      .cfg_ready_i   (cfgReady),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .err_code_o    (errCode),
      .err_idx_o     (errIdx),
      .err_rdata_o   (errRdata)
   );

   // Single comparison point
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearTable();
      for (int i = 0; i < NB; i++) begin
         tAddr[i] = '0;
         tData[i] = '0;
         tMask[i] = '0;
         tLast[i] = 1'b0;
      end
   endtask

   task automatic setEntry(input int idx, input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] m, input logic l);
      tAddr[idx] = a;
      tData[idx] = d;
      tMask[idx] = m;
      tLast[idx] = l;
   endtask

   task automatic expectTxn(input logic [4:0] a, input logic [31:0] d, input logic r);
      txn_t t;
      t.addr = a;
      t.data = d;
      t.rwn  = r;
      expQ.push_back(t);
   endtask

   // Called at a falling edge once this cycle's inputs are set: scores any
   // handshake, then moves to the next falling edge.
   task automatic clockCycle();
      txn_t t;
      if (cfgValid) validCycles++;
      if (cfgValid && cfgReady && !abort) begin
         checkOutput("req pending", 32'(expQ.size() > 0), 32'd1);
         if (expQ.size() > 0) begin
            t = expQ.pop_front();
            checkOutput("req addr", 32'(cfgAddr), 32'(t.addr));
            checkOutput("req data", cfgData, t.data);
            checkOutput("req rwn", 32'(cfgRwn), 32'(t.rwn));
         end
      end
      @(negedge clock);
      cycleNo++;
   endtask

   // Pulses start for one cycle; returns in the first cycle after it.
   task automatic applyStimulus();
      runStart = cycleNo;
      start = 1'b1;
      clockCycle();
      start = 1'b0;
   endtask

   // Returns at the falling edge of the done_o cycle, before it is clocked.
   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         clockCycle();
         n++;
      end
      checkOutput({tag, " done_o"}, 32'(done), 32'd1);
   endtask

   // Global guard so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      rstN     = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      cfgReady = 1'b0;
      cfgRdata = '0;
      clearTable();
      setEntry(0, 5'h01, 32'hDEAD_BEEF, 32'h0, 1'b1);

      // Reset state
      repeat (2) @(negedge clock);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst valid", 32'(cfgValid), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      checkOutput("rst err", 32'(err), 32'd0);
      checkOutput("rst errCode", 32'(errCode), 32'd0);
      checkOutput("rst errIdx", 32'(errIdx), 32'd0);
      checkOutput("rst errRdata", errRdata, 32'd0);
      checkOutput("rst tblIdx", 32'(tblIdx), 32'd0);
      checkOutput("rst addr", 32'(cfgAddr), 32'd0);
      checkOutput("rst data", cfgData, 32'd0);
      checkOutput("rst rwn", 32'(cfgRwn), 32'd0);
      rstN = 1'b1;
      @(negedge clock);

      // Write-only run, three back-to-back entries
      $display("[TB] write-only run");
      clearTable();
      setEntry(0, 5'h01, 32'hA0A0_0001, 32'h0, 1'b0);
      setEntry(1, 5'h03, 32'hB0B0_0003, 32'h0, 1'b0);
      setEntry(2, 5'h08, 32'hC0C0_0008, 32'h0, 1'b1);
      expectTxn(5'h01, 32'hA0A0_0001, 1'b0);
      expectTxn(5'h03, 32'hB0B0_0003, 1'b0);
      expectTxn(5'h08, 32'hC0C0_0008, 1'b0);
      cfgReady = 1'b1;
      validCycles = 0;
      applyStimulus();
      waitDone("wr-only", 10);
      checkOutput("wr-only latency", 32'(cycleNo - runStart), 32'd4);
      checkOutput("wr-only valid cycles", 32'(validCycles), 32'd3);
      checkOutput("wr-only err", 32'(err), 32'd0);
      checkOutput("wr-only errCode", 32'(errCode), 32'd0);
      checkOutput("wr-only drained", 32'(expQ.size()), 32'd0);
      start = 1'b1;
      clockCycle();
      start = 1'b0;
      checkOutput("start in DONE ignored", 32'(busy), 32'd0);
      checkOutput("done one cycle", 32'(done), 32'd0);

      // Readback pass
      $display("[TB] readback pass");
      clearTable();
      setEntry(0, 5'h01, 32'h0000_0005, 32'h0000_001F, 1'b1);
      expectTxn(5'h01, 32'h0000_0005, 1'b0);
      expectTxn(5'h01, 32'h0000_0005, 1'b1);
      cfgRdata = 32'h0000_0005;
      applyStimulus();
      waitDone("rb-pass", 10);
      checkOutput("rb-pass latency", 32'(cycleNo - runStart), 32'd3);
      checkOutput("rb-pass err", 32'(err), 32'd0);
      checkOutput("rb-pass errCode", 32'(errCode), 32'd0);
      checkOutput("rb-pass drained", 32'(expQ.size()), 32'd0);
      clockCycle();

      // Readback mismatch
      $display("[TB] readback mismatch");
      expectTxn(5'h01, 32'h0000_0005, 1'b0);
      expectTxn(5'h01, 32'h0000_0005, 1'b1);
      cfgRdata = 32'h0000_0007;
      applyStimulus();
      waitDone("mismatch", 10);
      checkOutput("mismatch latency", 32'(cycleNo - runStart), 32'd3);
      checkOutput("mismatch err", 32'(err), 32'd1);
      checkOutput("mismatch errCode", 32'(errCode), 32'd1);
      checkOutput("mismatch errIdx", 32'(errIdx), 32'd0);
      checkOutput("mismatch errRdata", errRdata, 32'h0000_0007);
      checkOutput("mismatch valid in ERR", 32'(cfgValid), 32'd0);
      clockCycle();
      validCycles = 0;
      repeat (4) clockCycle();
      checkOutput("mismatch no more requests", 32'(validCycles), 32'd0);
      checkOutput("mismatch idle", 32'(busy), 32'd0);
      checkOutput("mismatch drained", 32'(expQ.size()), 32'd0);

      // Timeout with ready held low
      $display("[TB] timeout");
      clearTable();
      setEntry(0, 5'h0A, 32'h1234_5678, 32'h0, 1'b1);
      cfgReady = 1'b0;
      validCycles = 0;
      applyStimulus();
      checkOutput("start clears err", 32'(err), 32'd0);
      checkOutput("start clears errCode", 32'(errCode), 32'd0);
      for (int i = 0; i < 10 && !done; i++) begin
         if (cfgValid) begin
            checkOutput("tmo addr stable", 32'(cfgAddr), 32'h0000_000A);
            checkOutput("tmo data stable", cfgData, 32'h1234_5678);
         end
         clockCycle();
      end
      checkOutput("tmo done_o", 32'(done), 32'd1);
      checkOutput("tmo valid cycles", 32'(validCycles), 32'd4);
      checkOutput("tmo latency", 32'(cycleNo - runStart), 32'd5);
      checkOutput("tmo valid dropped", 32'(cfgValid), 32'd0);
      checkOutput("tmo err", 32'(err), 32'd1);
      checkOutput("tmo errCode", 32'(errCode), 32'd2);
      checkOutput("tmo errIdx", 32'(errIdx), 32'd0);
      clockCycle();

      // Backpressure just below the timeout
      $display("[TB] backpressure");
      expectTxn(5'h0A, 32'h1234_5678, 1'b0);
      applyStimulus();
      repeat (3) clockCycle();
      cfgReady = 1'b1;
      waitDone("bp", 10);
      checkOutput("bp latency", 32'(cycleNo - runStart), 32'd5);
      checkOutput("bp err", 32'(err), 32'd0);
      checkOutput("bp errCode", 32'(errCode), 32'd0);
      checkOutput("bp drained", 32'(expQ.size()), 32'd0);
      clockCycle();

      // Abort during readback of entry 1, coinciding with a handshake
      $display("[TB] abort");
      clearTable();
      setEntry(0, 5'h02, 32'h0000_0011, 32'h0, 1'b0);
      setEntry(1, 5'h04, 32'h0000_0022, 32'hFFFF_FFFF, 1'b1);
      expectTxn(5'h02, 32'h0000_0011, 1'b0);
      expectTxn(5'h04, 32'h0000_0022, 1'b0);
      cfgRdata = 32'h0000_0022;
      applyStimulus();
      clockCycle();
      clockCycle();
      checkOutput("abort in RD rwn", 32'(cfgRwn), 32'd1);
      checkOutput("abort in RD idx", 32'(tblIdx), 32'd1);
      abort = 1'b1;
      clockCycle();
      abort = 1'b0;
      checkOutput("abort valid", 32'(cfgValid), 32'd0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort no done", 32'(done), 32'd0);
      checkOutput("abort err", 32'(err), 32'd1);
      checkOutput("abort errCode", 32'(errCode), 32'd3);
      checkOutput("abort errIdx", 32'(errIdx), 32'd1);
      checkOutput("abort drained", 32'(expQ.size()), 32'd0);
      clockCycle();

      // Full table without a last flag; start while busy is ignored
      $display("[TB] index limit");
      clearTable();
      for (int i = 0; i < NB; i++) begin
         setEntry(i, 5'(i + 16), 32'(i) * 32'h0101_0101 + 32'd1, 32'h0, 1'b0);
         expectTxn(5'(i + 16), 32'(i) * 32'h0101_0101 + 32'd1, 1'b0);
      end
      applyStimulus();
      checkOutput("restart clears err", 32'(err), 32'd0);
      checkOutput("restart clears errIdx", 32'(errIdx), 32'd0);
      start = 1'b1;
      clockCycle();
      clockCycle();
      start = 1'b0;
      waitDone("limit", 40);
      checkOutput("limit latency", 32'(cycleNo - runStart), 32'd17);
      checkOutput("limit final idx", 32'(tblIdx), 32'd15);
      checkOutput("limit err", 32'(err), 32'd0);
      checkOutput("limit drained", 32'(expQ.size()), 32'd0);
      clockCycle();
      checkOutput("limit idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
